quant_mcu_scheduler: RTL and testbench

- Sequences 8x8 DCT blocks from the luma and chroma DCT stages into the quantizer stage in strict JPEG MCU order: 4:2:0 gives Y0 Y1 Y2 Y3 Cb Cr; 4:4:4 gives Y Cb Cr.
- Drives the quantizer's enable pulse and the Q-table select.
- Tags each issued block and re-associates the tag with the quantizer's out_enable after the fixed pipeline latency.
- Gates issue on downstream credits, because the quantizer pipeline cannot stall.

---
 rtl/quant_mcu_scheduler.sv | 179 +++++++++++++++++
 tb/tb_quant_mcu_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_mcu_scheduler.sv
// MCU-order issue of DCT blocks into the quantizer, credit gated, with tag return tracking.
// Optional QSCHED_PERF_EN adds issue/stall performance counters.
module quant_mcu_scheduler #(
  parameter int MODE_420  = 1,
  parameter int CREDITS   = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       y_valid,
  output logic       y_ready,
  input  logic       cb_valid,
  output logic       cb_ready,
  input  logic       cr_valid,
  output logic       cr_ready,
  output logic       q_enable,
  output logic [1:0] q_sel,
  input  logic       q_out_enable,
  output logic       out_valid,
  output logic [1:0] out_comp,
  output logic [1:0] out_blk,
  output logic       out_mcu_last,
  input  logic       credit_ret,
  output logic       mcu_done,
  output logic       tag_err
`ifdef QSCHED_PERF_EN
  ,
  output logic [31:0] perf_blocks,
  output logic [31:0] perf_credit_stall,
  output logic [31:0] perf_src_stall
`endif
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [AW:0] FULL_CNT = TAG_DEPTH[AW:0];
  localparam logic [CW-1:0] CRED_MAX = CREDITS[CW-1:0];
  localparam logic [1:0] Y_LAST = (MODE_420 != 0) ? 2'd3 : 2'd0;

  typedef enum logic [1:0] {
    S_Y,
    S_CB,
    S_CR
  } state_t;

  state_t        state;
  logic [1:0]    y_idx;
  logic [CW-1:0] credits;
  logic [4:0]    tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic       src_valid;
  logic       has_credit;
  logic       fifo_full;
  logic       fifo_empty;
  logic       issue;
  logic       pop;
  logic [1:0] comp;
  logic [1:0] blk;
  logic       last;
  logic [4:0] head;

  always_comb begin
    comp      = 2'd0;
    blk       = 2'd0;
    last      = 1'b0;
    src_valid = 1'b0;
    unique case (1'b1)
      state == S_Y: begin
        src_valid = y_valid;
        blk       = y_idx;
      end
      state == S_CB: begin
        comp      = 2'd1;
        src_valid = cb_valid;
      end
      default: begin
        comp      = 2'd2;
        src_valid = cr_valid;
        last      = 1'b1;
      end
    endcase
  end

  assign has_credit = credits != '0;
  assign fifo_full  = count == FULL_CNT;
  assign fifo_empty = count == '0;
  // Reset forces every grant low even though the state already points at S_Y.
  assign issue = !rst && src_valid && has_credit && !fifo_full;
  assign pop   = q_out_enable && !fifo_empty;
  assign head  = tag_mem[rd_ptr];

  assign y_ready  = issue && (state == S_Y);
  assign cb_ready = issue && (state == S_CB);
  assign cr_ready = issue && (state == S_CR);
  assign q_enable = issue;
  assign q_sel    = issue ? comp : 2'd0;
  assign mcu_done = issue && last;

  assign out_valid    = pop;
  assign out_comp     = pop ? head[4:3] : 2'd0;
  assign out_blk      = pop ? head[2:1] : 2'd0;
  assign out_mcu_last = pop && head[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_Y;
      y_idx <= 2'd0;
    end else if (issue) begin
      unique case (1'b1)
        state == S_Y: begin
          if (y_idx == Y_LAST) begin
            state <= S_CB;
            y_idx <= 2'd0;
          end else begin
            y_idx <= y_idx + 2'd1;
          end
        end
        state == S_CB: state <= S_CR;
        default:       state <= S_Y;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CRED_MAX;
    end else if (issue && !credit_ret) begin
      credits <= credits - 1'b1;
    end else if (!issue && credit_ret && credits != CRED_MAX) begin
      credits <= credits + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[wr_ptr] <= {comp, blk, last};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_err <= 1'b0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (issue && !pop) begin
        count <= count + 1'b1;
      end else if (!issue && pop) begin
        count <= count - 1'b1;
      end
      if (q_out_enable && fifo_empty) tag_err <= 1'b1;
    end
  end

`ifdef QSCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_blocks       <= '0;
      perf_credit_stall <= '0;
      perf_src_stall    <= '0;
    end else begin
      if (issue) perf_blocks <= perf_blocks + 32'd1;
      if (src_valid && !has_credit) begin
        perf_credit_stall <= perf_credit_stall + 32'd1;
      end
      if (has_credit && !src_valid) begin
        perf_src_stall <= perf_src_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_quant_mcu_scheduler.sv
// Bench for quant_mcu_scheduler: three configs (420/C8, 420/C2, 444/C4) checked
// every cycle against an MCU-order/queue model, plus directed scenario checks.
module tb_quant_mcu_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] y_valid, y_ready, cb_valid, cb_ready, cr_valid, cr_ready;
  logic [2:0] q_enable, q_out_enable, out_valid, out_mcu_last;
  logic [2:0] credit_ret, mcu_done, tag_err;
  logic [2:0][1:0] q_sel, out_comp, out_blk;
`ifdef QSCHED_PERF_EN
  logic [2:0][31:0] perf_blocks, perf_credit_stall, perf_src_stall;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    quant_mcu_scheduler #(
      .MODE_420 (g == 2 ? 0 : 1),
      .CREDITS  (g == 0 ? 8 : (g == 1 ? 2 : 4)),
      .TAG_DEPTH(8)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .y_valid      (y_valid[g]),
      .y_ready      (y_ready[g]),
      .cb_valid     (cb_valid[g]),
      .cb_ready     (cb_ready[g]),
      .cr_valid     (cr_valid[g]),
      .cr_ready     (cr_ready[g]),
      .q_enable     (q_enable[g]),
      .q_sel        (q_sel[g]),
      .q_out_enable (q_out_enable[g]),
      .out_valid    (out_valid[g]),
      .out_comp     (out_comp[g]),
      .out_blk      (out_blk[g]),
      .out_mcu_last (out_mcu_last[g]),
      .credit_ret   (credit_ret[g]),
      .mcu_done     (mcu_done[g]),
      .tag_err      (tag_err[g])
`ifdef QSCHED_PERF_EN
      ,
      .perf_blocks      (perf_blocks[g]),
      .perf_credit_stall(perf_credit_stall[g]),
      .perf_src_stall   (perf_src_stall[g])
`endif
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model: position in the MCU sequence, credit count, queue of issued positions.
  int pos [3];
  int cred [3];
  int tq [3][$];
  bit terr [3];
  bit [3:0] pipe [3];
  bit stray [3];
  bit auto_ret [3];
  int unsigned pb [3], pcs [3], pss [3];

  logic obs_qe [3], obs_done [3], obs_ov [3], obs_cbr [3], obs_terr [3];
  logic [1:0] obs_sel [3];

  function automatic int mlen(int i);
    return (i == 2) ? 3 : 6;
  endfunction
  function automatic int ord_comp(int i, int p);
    if (mlen(i) == 3) return p;
    return (p < 4) ? 0 : p - 3;
  endfunction
  function automatic int ord_blk(int i, int p);
    return (mlen(i) == 6 && p < 4) ? p : 0;
  endfunction
  function automatic int ncred(int i);
    return (i == 0) ? 8 : ((i == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string tag, input int i,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic tick();
    bit iss [3];
    bit ov [3];
    bit qoe [3];
    bit srcv [3];
    int c, b, h;
    bit lst;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        pos[i] = 0; cred[i] = ncred(i); tq[i].delete(); terr[i] = 0;
        pb[i] = 0; pcs[i] = 0; pss[i] = 0;
      end
      qoe[i] = pipe[i][3] | stray[i];
      q_out_enable[i] = qoe[i];
      if (auto_ret[i]) credit_ret[i] = qoe[i] && tq[i].size() > 0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      c = ord_comp(i, pos[i]);
      b = ord_blk(i, pos[i]);
      lst = pos[i] == mlen(i) - 1;
      srcv[i] = (c == 0) ? y_valid[i] : ((c == 1) ? cb_valid[i] : cr_valid[i]);
      iss[i] = !rst && srcv[i] && cred[i] > 0 && tq[i].size() < 8;
      ov[i] = qoe[i] && tq[i].size() > 0;
      chk("y_ready", i, y_ready[i], iss[i] && c == 0);
      chk("cb_ready", i, cb_ready[i], iss[i] && c == 1);
      chk("cr_ready", i, cr_ready[i], iss[i] && c == 2);
      chk("q_enable", i, q_enable[i], iss[i]);
      chk("q_sel", i, q_sel[i], iss[i] ? c : 0);
      chk("mcu_done", i, mcu_done[i], iss[i] && lst);
      chk("out_valid", i, out_valid[i], ov[i]);
      h = ov[i] ? tq[i][0] : -1;
      chk("out_comp", i, out_comp[i], ov[i] ? ord_comp(i, h) : 0);
      chk("out_blk", i, out_blk[i], ov[i] ? ord_blk(i, h) : 0);
      chk("out_last", i, out_mcu_last[i], ov[i] && h == mlen(i) - 1);
      chk("tag_err", i, tag_err[i], terr[i]);
`ifdef QSCHED_PERF_EN
      chk("perf_blocks", i, perf_blocks[i], pb[i]);
      chk("perf_cstall", i, perf_credit_stall[i], pcs[i]);
      chk("perf_sstall", i, perf_src_stall[i], pss[i]);
`endif
      obs_qe[i] = q_enable[i];
      obs_sel[i] = q_sel[i];
      obs_done[i] = mcu_done[i];
      obs_ov[i] = out_valid[i];
      obs_cbr[i] = cb_ready[i];
      obs_terr[i] = tag_err[i];
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        if (qoe[i] && !ov[i]) terr[i] = 1;
        if (ov[i]) void'(tq[i].pop_front());
        if (iss[i]) begin
          tq[i].push_back(pos[i]);
          pos[i] = (pos[i] + 1) % mlen(i);
        end
        if (iss[i]) pb[i]++;
        if (srcv[i] && cred[i] == 0) pcs[i]++;
        if (cred[i] > 0 && !srcv[i]) pss[i]++;
        if (iss[i] && !credit_ret[i]) cred[i]--;
        else if (!iss[i] && credit_ret[i] && cred[i] < ncred(i)) cred[i]++;
      end
      pipe[i] = {pipe[i][2:0], iss[i]};
    end
    #1;
  endtask

  task automatic set_valids(input bit v);
    y_valid = {3{v}};
    cb_valid = {3{v}};
    cr_valid = {3{v}};
  endtask

  task automatic drain_reset();
    set_valids(0);
    for (int i = 0; i < 3; i++) begin
      auto_ret[i] = 1;
      stray[i] = 0;
    end
    repeat (6) tick();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    int seq420 [6] = '{0, 0, 0, 0, 1, 2};
    rst = 1;
    set_valids(0);
    credit_ret = '0;
    q_out_enable = '0;
    for (int i = 0; i < 3; i++) auto_ret[i] = 1;
    #1;
    tick();
    tick();
    chk("rst_qe", 0, obs_qe[0], 0);
    rst = 0;

    // Full-rate MCUs on inst0; inst1 runs dry after two issues.
    set_valids(1);
    auto_ret[1] = 0;
    credit_ret[1] = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("p1_qe", 0, obs_qe[0], 1);
      chk("p1_sel", 0, obs_sel[0], seq420[k % 6]);
      chk("p1_done", 0, obs_done[0], k == 5 || k == 11);
      chk("p1_c2", 1, obs_qe[1], k < 2);
    end
    credit_ret[1] = 1;
    tick();
    chk("p1_ret_cyc", 1, obs_qe[1], 0);
    credit_ret[1] = 0;
    tick();
    chk("p1_y2_qe", 1, obs_qe[1], 1);
    chk("p1_y2_sel", 1, obs_sel[1], 0);
    tick();
    chk("p1_after", 1, obs_qe[1], 0);

    // Only the current source may be granted.
    drain_reset();
    y_valid = '0;
    cb_valid = '1;
    cr_valid = '1;
    repeat (3) begin
      tick();
      chk("p2_noiss", 0, obs_qe[0], 0);
      chk("p2_cbr", 0, obs_cbr[0], 0);
    end
    y_valid = '1;
    repeat (4) begin
      tick();
      chk("p2_y", 0, obs_sel[0], 0);
      chk("p2_yqe", 0, obs_qe[0], 1);
    end
    y_valid = '0;
    tick();
    chk("p2_cb", 0, obs_sel[0], 1);
    tick();
    chk("p2_cr", 0, obs_sel[0], 2);
    chk("p2_cr_done", 0, obs_done[0], 1);

    // credit_ret alongside an issue at credits = 1.
    drain_reset();
    auto_ret[1] = 0;
    credit_ret[1] = 0;
    set_valids(1);
    tick();
    chk("p3_i1", 1, obs_qe[1], 1);
    credit_ret[1] = 1;
    tick();
    chk("p3_i2", 1, obs_qe[1], 1);
    credit_ret[1] = 0;
    tick();
    chk("p3_i3", 1, obs_qe[1], 1);
    tick();
    chk("p3_dry", 1, obs_qe[1], 0);

    // Reset two cycles after Y1; the quantizer pipe keeps returning.
    drain_reset();
    set_valids(1);
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    chk("p4_rst_qe", 0, obs_qe[0], 0);
    rst = 0;
    set_valids(0);
    tick();
    tick();
    chk("p4_ov", 0, obs_ov[0], 0);
    chk("p4_terr", 0, obs_terr[0], 1);

    // Randomized traffic with stray returns and occasional resets.
    drain_reset();
    for (int i = 0; i < 3; i++) auto_ret[i] = 0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 3; i++) begin
        y_valid[i] = $urandom_range(0, 3) != 0;
        cb_valid[i] = $urandom_range(0, 3) != 0;
        cr_valid[i] = $urandom_range(0, 3) != 0;
        credit_ret[i] = $urandom_range(0, 2) == 0;
        stray[i] = $urandom_range(0, 60) == 0;
      end
      rst = $urandom_range(0, 150) == 0;
      tick();
    end
    rst = 0;

    // 4:4:4 MCUs with Cr arriving five cycles late.
    drain_reset();
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 8; k++) begin
        y_valid[2] = 1;
        cb_valid[2] = 1;
        cr_valid[2] = k == 7;
        tick();
        chk("p6_qe", 2, obs_qe[2], k == 0 || k == 1 || k == 7);
        chk("p6_sel", 2, obs_sel[2], k == 1 ? 1 : (k == 7 ? 2 : 0));
      end
    end
`ifdef QSCHED_PERF_EN
    chk("p6_blocks", 2, perf_blocks[2], 9);
    chk("p6_src_stall", 2, perf_src_stall[2], 15);
`endif
    set_valids(0);
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
